// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the per-requester request and response handshakes of the shared ALU
// arbiter. Vectors are packed per requester: requester i owns bit i of every
// valid/ready vector, bits [i*DW +: DW] of req_a/req_b and bits [i*3 +: 3] of
// req_op. rsp_data is shared and is meaningful only where rsp_valid is set.
//
// Ports (signals):
//   req_valid  NREQ      request valid, requester -> arbiter
//   req_ready  NREQ      request accept, arbiter -> requester (one-hot or zero)
//   req_a      NREQ*DW   operand A
//   req_b      NREQ*DW   operand B
//   req_op     NREQ*3    ALU op code
//   rsp_valid  NREQ      response valid, arbiter -> requester (one-hot or zero)
//   rsp_ready  NREQ      response accept, requester -> arbiter
//   rsp_data   DW        shared result
// Modports: master (requester side), slave (arbiter side).
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*3-1:0]  req_op;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external registered ALU among NREQ requesters with round-robin
// arbitration. A request is granted in IDLE, its operands are driven to the
// ALU (ISSUE), the ALU's one-clock register latency is waited out (WAIT), and
// the captured result is returned to the granted requester (RESP) until that
// requester accepts it.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   host      slave modport of alu_share_arbiter_if (request/response handshakes)
//   alu_a     out  DW   ALU operand A, held from grant to next grant
//   alu_b     out  DW   ALU operand B, held from grant to next grant
//   alu_op    out  3    ALU op code, passed through uninterpreted
//   alu_r     in   DW   ALU registered result
//   busy      out  1    high in every state except IDLE
//   ops_done  out  CW   count of completed response handshakes (wraps)
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   host,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [2:0]           alu_op,
    input  logic [DW-1:0]        alu_r,
    output logic                 busy,
    output logic [CW-1:0]        ops_done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   winner;
    logic            found;
    logic [NREQ-1:0] ready_vec;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping
    // modulo NREQ. Purely combinational so a requester that drops req_valid
    // before being accepted is simply skipped in the same cycle.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = rr_ptr;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && host.req_valid[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // The accept strobe exists only in IDLE; it is also gated by rst_n so
    // every output reads zero while reset is held.
    always_comb begin
        ready_vec = '0;
        if (rst_n && state == IDLE && found) begin
            ready_vec[winner] = 1'b1;
        end
    end

    assign host.req_ready = ready_vec;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;

    // Transaction FSM with registered outputs. busy is updated together with
    // the state so it tracks "state != IDLE" without decode logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy        <= 1'b0;
            ops_done    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_a  <= host.req_a[winner*DW +: DW];
                        alu_b  <= host.req_b[winner*DW +: DW];
                        alu_op <= host.req_op[winner*3 +: 3];
                        gnt    <= winner;
                        rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    rsp_data_q       <= alu_r;
                    rsp_valid_q[gnt] <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    if (host.rsp_ready[gnt]) begin
                        rsp_valid_q <= '0;
                        ops_done    <= ops_done + 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered 8-bit ALU (op codes 0–7: ADD, SUB, NOT A, NAND, NOR, AND, OR, XOR; result registered on each clk rising edge) among NREQ requesters.
- Arbitration is round-robin.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- The block sits between the requesters and the ALU. It drives the ALU operand and op inputs, waits out the ALU's one-clock register latency, captures the result and returns it to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, operand/result width (must equal ALU width).
- CW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept (one-hot or zero).
- req_a  in  NREQ*DW  operand A, requester i at bits [i*DW +: DW].
- req_b  in  NREQ*DW  operand B, same packing.
- req_op  in  NREQ*3  op code, requester i at bits [i*3 +: 3].
- rsp_valid  out  NREQ  per-requester response valid (one-hot or zero).
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_data  out  DW  result, shared; meaningful only where rsp_valid is set.
- alu_a  out  DW  to ALU operand A.
- alu_b  out  DW  to ALU operand B.
- alu_op  out  3  to ALU op.
- alu_r  in  DW  from ALU registered result.
- busy  out  1  high in every state except IDLE.
- ops_done  out  CW  count of completed response handshakes.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, rr pointer=0;
  - alu_a, alu_b, alu_op, rsp_data and ops_done = 0;
  - req_ready, rsp_valid and busy = 0.
- Reset mid-operation abandons the transaction; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr pointer upward, modulo NREQ.
  - req_ready[winner] is asserted combinationally in IDLE only.
  - On the handshake edge, the block latches req_a/req_b/req_op[winner] into alu_a/alu_b/alu_op and the grant index into gnt.
  - On the same edge, rr pointer ← (winner+1) mod NREQ and state → ISSUE.
  - No request valid: stay in IDLE with outputs held.
- ISSUE: ALU inputs are stable; the ALU registers its result at the end of this cycle. Always → WAIT.
- WAIT: alu_r is valid. At the end of the cycle, rsp_data ← alu_r, rsp_valid[gnt] ← 1, state → RESP.
- RESP:
  - Hold rsp_valid[gnt] and rsp_data stable until rsp_ready[gnt]=1 on an edge.
  - On that edge: rsp_valid ← 0, ops_done ← ops_done+1 (wraps at 2^CW, no saturation), state → IDLE.
  - rsp_ready of non-granted requesters is ignored.
- alu_a, alu_b and alu_op hold their value from grant until the next grant. They do not return to 0.
- Latency: request handshake at edge E0 → rsp_valid high after edge E0+2.
- Minimum transaction period is 4 cycles. A new grant may occur in the IDLE cycle right after a response handshake.
- Requests are not committed until the handshake. A requester may drop req_valid before req_ready, and the arbiter then re-evaluates that same cycle.
- No requester is granted twice while another valid requester waits: starvation-free with a bound of NREQ transactions.
- Arithmetic is the ALU's: modulo 2^DW, no carry/borrow out. The arbiter does not interpret op; all 8 codes pass through.
- rsp_data keeps its last value after the response handshake.

Test Plan:
- Reset, then requester 0 sends A=200, B=100, op=0:
  - req_ready[0] asserted in the same cycle;
  - rsp_valid[0]=1 two edges later with rsp_data=44 (300 mod 256);
  - ops_done=1 after rsp_ready.
- Requester 2 sends A=5, B=10, op=1 → rsp_data=251. Then A=0xF0, B=0x3C, op=3 → rsp_data=0xCF.
- All four req_valid held high, rsp_ready tied high, each requester using op=7 with distinct operands:
  - grant order 0,1,2,3,0,1;
  - each rsp_valid goes only to the granted index, with the correct XOR;
  - one grant every 4 cycles.
- Hold rsp_ready[1] low for 5 cycles during a requester-1 transaction while requesters 0 and 3 are valid:
  - rsp_valid[1] and rsp_data stay stable;
  - busy=1 and no req_ready is asserted;
  - the next grant after the handshake goes to requester 3 (rr pointer=2, requester 2 idle).
- Assert rst_n low during WAIT:
  - all outputs are 0 immediately (asynchronously) and no response appears;
  - after release, with requesters 1 and 3 valid, requester 1 is granted first (pointer=0).
- Preload ops_done to 0xFFFF by running 65535 transactions (or via a bench force), then complete one more → ops_done=0.
